model_trainer_differentiation_stream: RTL and testbench
=======================================================

Name: model_trainer_differentiation_stream

Overview:
Streaming temporal-differentiation engine for the NTM trainer: takes LENGTH_IN time-steps of SIZE_IN-element signed vectors and emits the scaled backward difference (x[t][i] - x[t-1][i]) >>> SHIFT per element.
It generalises the fixed-size trainer differentiation constants into a run-time-sized, shift-scaled, saturating block.
It holds the previous vector in an internal buffer of SIZE_MAX entries.
It sits between the controller output stream and the trainer gradient path.

Parameters:
DATA_SIZE, 64, signed element width and width of SIZE_IN/LENGTH_IN
CONTROL_SIZE, 4, width of SHIFT_IN
SIZE_MAX, 64, previous-vector buffer depth (max elements per vector)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  begin a run; sampled in IDLE only
READY  out  1  one-cycle pulse when a run completes
MODE_IN  in  1  t=0 policy: 0 emits zero, 1 passes x[0][i] through
SHIFT_IN  in  CONTROL_SIZE  arithmetic right shift applied to differences (time-step 2^SHIFT)
SIZE_IN  in  DATA_SIZE  elements per vector
LENGTH_IN  in  DATA_SIZE  number of time-steps
DATA_ENABLE  out  1  high while the block can accept an element (RUN state)
DATA_IN_ENABLE  in  1  element valid; transfer = DATA_IN_ENABLE & DATA_ENABLE
DATA_IN  in  DATA_SIZE  signed element x[t][i]
DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT valid
DATA_OUT  out  DATA_SIZE  signed result
INDEX_I_OUT  out  DATA_SIZE  element index i of DATA_OUT
INDEX_T_OUT  out  DATA_SIZE  time index t of DATA_OUT

Behaviour:
- Reset (RST=0, any cycle incl. mid-run): state IDLE; READY, DATA_ENABLE, DATA_OUT_ENABLE=0; DATA_OUT, INDEX_I_OUT, INDEX_T_OUT=0; counters=0. Buffer contents not reset (never read before written).
- FSM states: IDLE, RUN, DONE.
- IDLE: on START=1, latch the following and go to RUN:
  - SIZE_IN, clamped to SIZE_MAX if larger;
  - LENGTH_IN, MODE_IN, SHIFT_IN;
  - i=t=0.
- IDLE: if the latched size or length is 0, go to DONE instead of RUN.
- START while in RUN or DONE is ignored; DATA_IN_ENABLE outside RUN is ignored.
- RUN: DATA_ENABLE=1. On each transfer:
  - compute d = DATA_IN - buf[i] in DATA_SIZE+1 bits;
  - r = d >>> SHIFT (sign-extending);
  - saturate r to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1];
  - if t=0, r = 0 (MODE=0) or DATA_IN (MODE=1), with no shift;
  - write buf[i] = DATA_IN;
  - register DATA_OUT=r, INDEX_I_OUT=i, INDEX_T_OUT=t; DATA_OUT_ENABLE=1 on the next cycle (latency 1).
- Index advance: i increments; at i=size-1, i wraps to 0 and t increments.
- Transfer of i=size-1, t=length-1: go to DONE; DATA_ENABLE deasserts the following cycle.
- Back-to-back transfers are supported, one per cycle. Gaps on DATA_IN_ENABLE stall without output.
- DATA_OUT_ENABLE is low on cycles with no transfer in the previous cycle. DATA_OUT and indices hold their last value.
- DONE: READY=1 for exactly one cycle, coinciding with the last DATA_OUT_ENABLE pulse (or the cycle after START for empty runs). Then go to IDLE.
- START in the cycle READY is high is ignored; a new run starts no earlier than the next cycle.
- Counters are DATA_SIZE wide. Buffer address uses clog2(SIZE_MAX) bits.

Test Plan:
- Basic differentiation: SIZE=2, LENGTH=3, SHIFT=0, MODE=0, inputs t0={5,-3}, t1={8,-1}, t2={4,-1}, back-to-back. Required outputs {0,0},{3,2},{-4,0}, indices (0,0)…(1,2). READY coincides with the 6th DATA_OUT_ENABLE.
- Pass-through and scaling: MODE=1, SHIFT=2, SIZE=1, LENGTH=3, inputs 12, 4, 5. Required outputs 12, -2 (=-8>>>2), 0 (=1>>>2).
- Saturation (DATA_SIZE=8): SIZE=1, LENGTH=2, SHIFT=0, inputs -128 then 127 gives 127. Inputs 127 then -128 gives -128.
- Stall and clamp (SIZE_MAX=4): SIZE_IN=9 is treated as 4. Random DATA_IN_ENABLE gaps. Exactly 4*LENGTH outputs in order, each exactly 1 cycle after its transfer.
- Empty run and ignored inputs: LENGTH_IN=0 gives READY one cycle after START and no DATA_OUT_ENABLE. START pulsed mid-run has no effect. DATA_IN_ENABLE in IDLE produces no output.
- Reset mid-run: assert RST=0 after 3 transfers. All outputs are 0 immediately (asynchronous). A fresh run after release produces results matching the first scenario.

Source files
------------

// File: rtl/model_trainer_differentiation_stream.sv
// Streaming backward-difference engine: emits (x[t][i] - x[t-1][i]) >>> SHIFT per element,
// saturated to DATA_SIZE bits, with a selectable policy for the first time-step.
module model_trainer_differentiation_stream #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int SIZE_MAX     = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic                    MODE_IN,
    input  logic [CONTROL_SIZE-1:0] SHIFT_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_IN,
    input  logic [DATA_SIZE-1:0]    LENGTH_IN,
    output logic                    DATA_ENABLE,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic [DATA_SIZE-1:0]    INDEX_I_OUT,
    output logic [DATA_SIZE-1:0]    INDEX_T_OUT
);

    localparam int ADDR_W = (SIZE_MAX > 1) ? $clog2(SIZE_MAX) : 1;
    localparam logic [DATA_SIZE-1:0] SIZE_MAX_V = DATA_SIZE'(SIZE_MAX);
    localparam logic [DATA_SIZE-1:0] ZERO_V     = {DATA_SIZE{1'b0}};
    localparam logic [DATA_SIZE-1:0] ONE_V      = {{(DATA_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_r, next_state_s;
    logic [DATA_SIZE-1:0]         size_r, length_r, i_r, t_r;
    logic                         mode_r;
    logic [CONTROL_SIZE-1:0]      shift_r;
    logic [DATA_SIZE-1:0]         buffer_r [SIZE_MAX];
    logic                         ready_r, data_enable_r, out_enable_r;
    logic [DATA_SIZE-1:0]         data_out_r, index_i_r, index_t_r;

    logic                         transfer_s, last_i_s, last_t_s;
    logic [DATA_SIZE-1:0]         size_clamped_s, prev_s, result_s;
    logic signed [DATA_SIZE:0]    diff_s, shifted_s;

    // Clamp a (DATA_SIZE+1)-bit difference into the signed DATA_SIZE range.
    function automatic logic [DATA_SIZE-1:0] saturate(input logic [DATA_SIZE:0] v);
        if (v[DATA_SIZE] != v[DATA_SIZE-1]) begin
            saturate = v[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                    : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else begin
            saturate = v[DATA_SIZE-1:0];
        end
    endfunction

    // Datapath: element difference, scaling, saturation and t=0 policy.
    always_comb begin
        transfer_s     = DATA_IN_ENABLE && (state_r == RUN);
        size_clamped_s = (SIZE_IN > SIZE_MAX_V) ? SIZE_MAX_V : SIZE_IN;
        last_i_s       = (i_r == size_r - ONE_V);
        last_t_s       = (t_r == length_r - ONE_V);
        prev_s         = buffer_r[i_r[ADDR_W-1:0]];
        diff_s         = $signed({DATA_IN[DATA_SIZE-1], DATA_IN}) - $signed({prev_s[DATA_SIZE-1], prev_s});
        shifted_s      = diff_s >>> shift_r;
        if (t_r == ZERO_V) begin
            result_s = mode_r ? DATA_IN : ZERO_V;
        end else begin
            result_s = saturate(shifted_s);
        end
    end

    // Next-state logic; empty runs skip straight to DONE so READY still pulses.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    if ((size_clamped_s == ZERO_V) || (LENGTH_IN == ZERO_V)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (transfer_s && last_i_s && last_t_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, run configuration, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= IDLE;
            size_r        <= ZERO_V;
            length_r      <= ZERO_V;
            mode_r        <= 1'b0;
            shift_r       <= {CONTROL_SIZE{1'b0}};
            i_r           <= ZERO_V;
            t_r           <= ZERO_V;
            ready_r       <= 1'b0;
            data_enable_r <= 1'b0;
            out_enable_r  <= 1'b0;
            data_out_r    <= ZERO_V;
            index_i_r     <= ZERO_V;
            index_t_r     <= ZERO_V;
        end else begin
            state_r       <= next_state_s;
            ready_r       <= (next_state_s == DONE);
            data_enable_r <= (next_state_s == RUN);
            out_enable_r  <= transfer_s;
            if ((state_r == IDLE) && START) begin
                size_r   <= size_clamped_s;
                length_r <= LENGTH_IN;
                mode_r   <= MODE_IN;
                shift_r  <= SHIFT_IN;
                i_r      <= ZERO_V;
                t_r      <= ZERO_V;
            end else if (transfer_s) begin
                data_out_r <= result_s;
                index_i_r  <= i_r;
                index_t_r  <= t_r;
                if (last_i_s) begin
                    i_r <= ZERO_V;
                    t_r <= t_r + ONE_V;
                end else begin
                    i_r <= i_r + ONE_V;
                end
            end
        end
    end

    // Previous-vector buffer; every entry is written at t=0 before it is ever read.
    always_ff @(posedge CLK) begin
        if (transfer_s) begin
            buffer_r[i_r[ADDR_W-1:0]] <= DATA_IN;
        end
    end

    assign READY           = ready_r;
    assign DATA_ENABLE     = data_enable_r;
    assign DATA_OUT_ENABLE = out_enable_r;
    assign DATA_OUT        = data_out_r;
    assign INDEX_I_OUT     = index_i_r;
    assign INDEX_T_OUT     = index_t_r;

endmodule

// File: tb/tb_model_trainer_differentiation_stream.sv
// Table-driven bench for the differentiation stream (8-bit data, 4-entry buffer)
// plus directed sequences for empty runs, ignored inputs and mid-run reset.
module tb_model_trainer_differentiation_stream;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       READY;
    logic       MODE_IN = 1'b0;
    logic [3:0] SHIFT_IN = 4'd0;
    logic [7:0] SIZE_IN = 8'd0;
    logic [7:0] LENGTH_IN = 8'd0;
    logic       DATA_ENABLE;
    logic       DATA_IN_ENABLE = 1'b0;
    logic [7:0] DATA_IN = 8'd0;
    logic       DATA_OUT_ENABLE;
    logic [7:0] DATA_OUT;
    logic [7:0] INDEX_I_OUT;
    logic [7:0] INDEX_T_OUT;

    int tests = 0;
    int fails = 0;

    model_trainer_differentiation_stream #(
        .DATA_SIZE(8), .CONTROL_SIZE(4), .SIZE_MAX(4)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .MODE_IN(MODE_IN), .SHIFT_IN(SHIFT_IN), .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN),
        .DATA_ENABLE(DATA_ENABLE), .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_IN(DATA_IN),
        .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT),
        .INDEX_I_OUT(INDEX_I_OUT), .INDEX_T_OUT(INDEX_T_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int             size;
        int             length;
        bit             mode;
        bit [3:0]       shift;
        bit             gaps;
        bit             mid_start;
        int             n;
        bit [11:0][7:0] din;
        bit [11:0][7:0] dout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cfg(input int vi, input int size, input int length, input bit mode,
                       input int shift, input bit gaps, input bit mid_start);
        vecs[vi].size      = size;
        vecs[vi].length    = length;
        vecs[vi].mode      = mode;
        vecs[vi].shift     = shift[3:0];
        vecs[vi].gaps      = gaps;
        vecs[vi].mid_start = mid_start;
        vecs[vi].n         = 0;
        vecs[vi].din       = '0;
        vecs[vi].dout      = '0;
    endtask

    task automatic add(input int vi, input int d, input int e);
        vecs[vi].din[vecs[vi].n]  = d[7:0];
        vecs[vi].dout[vecs[vi].n] = e[7:0];
        vecs[vi].n++;
    endtask

    // Runs vector vi; stop_after >= 0 abandons the run after that many transfers.
    task automatic run_vec(input int vi, input int stop_after);
        vec_t v;
        int   eff;
        v   = vecs[vi];
        eff = (v.size > 4) ? 4 : v.size;
        @(posedge CLK); #1;
        START = 1'b1; SIZE_IN = v.size[7:0]; LENGTH_IN = v.length[7:0];
        MODE_IN = v.mode; SHIFT_IN = v.shift;
        @(posedge CLK); #1;
        START = 1'b0;
        check("data_enable_on", DATA_ENABLE, 1);
        if (v.mid_start) begin
            START = 1'b1; SIZE_IN = 8'd1; LENGTH_IN = 8'd0;
        end
        for (int k = 0; k < v.n; k++) begin
            if (stop_after >= 0 && k == stop_after) return;
            if (v.gaps && $urandom_range(0, 1) == 1) begin
                DATA_IN_ENABLE = 1'b0;
                @(posedge CLK); #1;
                check("gap_no_output", DATA_OUT_ENABLE, 0);
            end
            DATA_IN_ENABLE = 1'b1;
            DATA_IN        = v.din[k];
            @(posedge CLK); #1;
            DATA_IN_ENABLE = 1'b0;
            check("out_enable", DATA_OUT_ENABLE, 1);
            check("data_out", DATA_OUT, v.dout[k]);
            check("index_i", INDEX_I_OUT, k % eff);
            check("index_t", INDEX_T_OUT, k / eff);
            check("ready", READY, (k == v.n - 1) ? 1 : 0);
        end
        check("enable_drop", DATA_ENABLE, 0);
        @(posedge CLK); #1;
        START = 1'b0;
        check("ready_low_after", READY, 0);
        check("no_extra_output", DATA_OUT_ENABLE, 0);
        @(posedge CLK); #1;
        check("no_restart", READY | DATA_ENABLE, 0);
    endtask

    initial begin
        cfg(0, 2, 3, 1'b0, 0, 1'b0, 1'b0);
        add(0, 5, 0);    add(0, -3, 0);  add(0, 8, 3);    add(0, -1, 2);
        add(0, 4, -4);   add(0, -1, 0);
        cfg(1, 1, 3, 1'b1, 2, 1'b0, 1'b0);
        add(1, 12, 12);  add(1, 4, -2);  add(1, 5, 0);
        cfg(2, 1, 2, 1'b0, 0, 1'b0, 1'b0);
        add(2, -128, 0); add(2, 127, 127);
        cfg(3, 1, 2, 1'b0, 0, 1'b0, 1'b0);
        add(3, 127, 0);  add(3, -128, -128);
        cfg(4, 9, 2, 1'b0, 1, 1'b1, 1'b1);
        add(4, 10, 0);   add(4, -10, 0); add(4, 100, 0);  add(4, 0, 0);
        add(4, 20, 5);   add(4, -20, -5); add(4, -100, -100); add(4, 7, 3);
        cfg(5, 3, 2, 1'b1, 3, 1'b1, 1'b0);
        add(5, -7, -7);  add(5, 100, 100); add(5, -128, -128);
        add(5, -16, -2); add(5, -100, -25); add(5, 127, 31);

        #12;
        check("reset_ready", READY, 0);
        check("reset_data_enable", DATA_ENABLE, 0);
        check("reset_out_enable", DATA_OUT_ENABLE, 0);
        check("reset_outputs", {DATA_OUT, INDEX_I_OUT, INDEX_T_OUT}, 0);
        @(posedge CLK); #1;
        RST = 1'b1;

        for (int vi = 0; vi < 6; vi++) run_vec(vi, -1);

        // Empty runs: zero length, then zero size.
        for (int e = 0; e < 2; e++) begin
            @(posedge CLK); #1;
            START = 1'b1;
            SIZE_IN   = (e == 0) ? 8'd2 : 8'd0;
            LENGTH_IN = (e == 0) ? 8'd0 : 8'd3;
            @(posedge CLK); #1;
            START = 1'b0;
            check("empty_ready", READY, 1);
            check("empty_no_output", DATA_OUT_ENABLE | DATA_ENABLE, 0);
            @(posedge CLK); #1;
            check("empty_ready_pulse", READY, 0);
        end

        // Data offered in IDLE is ignored.
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = 8'd55;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            check("idle_no_output", DATA_OUT_ENABLE, 0);
        end
        DATA_IN_ENABLE = 1'b0;

        // Asynchronous reset mid-run, then a clean rerun.
        run_vec(0, 3);
        #2;
        RST = 1'b0;
        #1;
        check("rst_ready", READY, 0);
        check("rst_data_enable", DATA_ENABLE, 0);
        check("rst_out_enable", DATA_OUT_ENABLE, 0);
        check("rst_outputs", {DATA_OUT, INDEX_I_OUT, INDEX_T_OUT}, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        run_vec(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
